// File: rtl/tea_rr_sched.sv
// tea_rr_sched
// ------------
// Round-robin scheduler sharing one TEA encryption core between N_REQ
// requesters. One 64-bit block is accepted at a time, the core is launched
// with a single-cycle start pulse, and the ciphertext is returned tagged
// with the index of the requester that supplied the plaintext.
//
// Optional feature: define TEA_SCHED_TIMEOUT_EN to build a BUSY-state
// watchdog that converts a hung core into an error response (rsp_err=1,
// zero data). Without the macro, rsp_err is tied to 0 and BUSY waits for
// the core indefinitely.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset (shared with core)
//   req_valid[N_REQ]    per-requester block valid
//   req_ready[N_REQ]    per-requester accept, one-hot or zero
//   req_v0/req_v1       packed words, requester i at [32i+31:32i]
//   core_start          one-cycle launch pulse to the core
//   core_vi0/core_vi1   plaintext words to the core
//   core_idle           core idle flag
//   core_vo0/core_vo1   ciphertext words from the core
//   rsp_valid/rsp_ready result handshake
//   rsp_v0/rsp_v1       ciphertext (zero on error)
//   rsp_id              index of the requester owning the result
//   rsp_err             watchdog fired, data invalid
//   dbg_state           current FSM state (IDLE=0, LAUNCH=1, BUSY=2, RESP=3)
//
// Handshake semantics (both request and response sides): a transfer occurs
// on a rising clk edge where valid and ready are both 1. A source holds
// valid and its data stable until the transfer; a requester may withdraw
// req_valid before it is granted. req_ready is combinational from
// req_valid, core_idle and the FSM state; rsp_* are registered.

module tea_rr_sched #(
    parameter int N_REQ       = 4,
    parameter int ID_W        = 2,
    parameter int TIMEOUT_CYC = 512
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    output logic [N_REQ-1:0]      req_ready,
    input  logic [32*N_REQ-1:0]   req_v0,
    input  logic [32*N_REQ-1:0]   req_v1,
    output logic                  core_start,
    output logic [31:0]           core_vi0,
    output logic [31:0]           core_vi1,
    input  logic                  core_idle,
    input  logic [31:0]           core_vo0,
    input  logic [31:0]           core_vo1,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [31:0]           rsp_v0,
    output logic [31:0]           rsp_v1,
    output logic [ID_W-1:0]       rsp_id,
    output logic                  rsp_err,
    output logic [1:0]            dbg_state
);

    // Elaboration-time parameter sanity.
    if (N_REQ < 2 || N_REQ > 16 || N_REQ > (1 << ID_W) || TIMEOUT_CYC < 2) begin : g_bad_params
        $error("tea_rr_sched: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [ID_W-1:0] last_q;
    logic [ID_W-1:0] id_q;
    logic [31:0]     vi0_q, vi1_q;
    logic [31:0]     rsp_v0_q, rsp_v1_q;

    logic            grant_any;
    logic [ID_W-1:0] grant_idx;
    logic [N_REQ-1:0] grant_oh;
    logic [31:0]     sel_v0, sel_v1;
    logic            grant;
    logic            wd_fire;

    // Round-robin search: the lowest valid index above last wins; if none,
    // wrap around to the lowest valid index overall. Scanning downward makes
    // the final assignment in each class the lowest index.
    always_comb begin
        logic            hi_any;
        logic [ID_W-1:0] hi_idx;
        logic [ID_W-1:0] lo_idx;
        hi_any    = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        grant_any = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                grant_any = 1'b1;
                lo_idx    = ID_W'(i);
                if (i > int'(last_q)) begin
                    hi_any = 1'b1;
                    hi_idx = ID_W'(i);
                end
            end
        end
        grant_idx = hi_any ? hi_idx : lo_idx;
    end

    // Decode the winner into a one-hot vector and select its data words.
    always_comb begin
        grant_oh = '0;
        sel_v0   = '0;
        sel_v1   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                grant_oh[i] = 1'b1;
                sel_v0      = req_v0[32*i +: 32];
                sel_v1      = req_v1[32*i +: 32];
            end
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        state_d    = state_q;
        req_ready  = '0;
        core_start = 1'b0;
        grant      = 1'b0;
        case (state_q)
            IDLE: begin
                // Gated by rst so a requester never sees an accept that
                // the reset is about to discard.
                if (!rst && core_idle && grant_any) begin
                    grant     = 1'b1;
                    req_ready = grant_oh;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                core_start = 1'b1;
                state_d    = BUSY;
            end
            BUSY: begin
                // core_idle wins over a simultaneous watchdog expiry.
                if (core_idle || wd_fire) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            last_q   <= ID_W'(N_REQ - 1);
            id_q     <= '0;
            vi0_q    <= '0;
            vi1_q    <= '0;
            rsp_v0_q <= '0;
            rsp_v1_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                vi0_q  <= sel_v0;
                vi1_q  <= sel_v1;
                id_q   <= grant_idx;
                last_q <= grant_idx;
            end
            if (state_q == BUSY) begin
                if (core_idle) begin
                    rsp_v0_q <= core_vo0;
                    rsp_v1_q <= core_vo1;
                end else if (wd_fire) begin
                    rsp_v0_q <= '0;
                    rsp_v1_q <= '0;
                end
            end
        end
    end

`ifdef TEA_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;

    logic [WD_W-1:0] wd_q;
    logic            err_q;

    // Fires on the BUSY cycle whose increment would reach TIMEOUT_CYC, so
    // BUSY lasts exactly TIMEOUT_CYC cycles before the error response.
    assign wd_fire = (state_q == BUSY) && !core_idle &&
                     (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q <= '0;
        end else if (state_q == LAUNCH) begin
            wd_q <= '0;
        end else if (state_q == BUSY) begin
            wd_q <= wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (state_q == BUSY) begin
            if (core_idle) begin
                err_q <= 1'b0;
            end else if (wd_fire) begin
                err_q <= 1'b1;
            end
        end
    end

    assign rsp_err = err_q;
`else
    assign wd_fire = 1'b0;
    assign rsp_err = 1'b0;
`endif

    assign core_vi0  = vi0_q;
    assign core_vi1  = vi1_q;
    assign rsp_valid = (state_q == RESP);
    assign rsp_v0    = rsp_v0_q;
    assign rsp_v1    = rsp_v1_q;
    assign rsp_id    = id_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_tea_rr_sched.sv
// Directed bench for tea_rr_sched with a stub core that stays busy for 10
// cycles after start and returns vo = vi ^ 32'hA5A5A5A5.

module tb_tea_rr_sched;

  localparam int N_REQ       = 4;
  localparam int ID_W        = 2;
  localparam int TIMEOUT_CYC = 16;
  localparam int W           = 1 + ID_W + 64;
  localparam logic [31:0] K  = 32'hA5A5A5A5;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [32*N_REQ-1:0] req_v0;
  logic [32*N_REQ-1:0] req_v1;
  logic                core_start;
  logic [31:0]         core_vi0, core_vi1;
  logic                core_idle;
  logic [31:0]         core_vo0, core_vo1;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [31:0]         rsp_v0, rsp_v1;
  logic [ID_W-1:0]     rsp_id;
  logic                rsp_err;
  logic [1:0]          dbg_state;

  logic [W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  tea_rr_sched #(
    .N_REQ(N_REQ), .ID_W(ID_W), .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_v0(req_v0), .req_v1(req_v1),
    .core_start(core_start), .core_vi0(core_vi0), .core_vi1(core_vi1),
    .core_idle(core_idle), .core_vo0(core_vo0), .core_vo1(core_vo1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_v0(rsp_v0), .rsp_v1(rsp_v1), .rsp_id(rsp_id), .rsp_err(rsp_err),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation time limit reached, n_fail=%0d", n_fail);
    $fatal(1, "time limit");
  end

  // ---------------- stub core ----------------
  logic [3:0]  stub_cnt;
  logic [31:0] stub_vo0, stub_vo1;
  logic        stub_hold;   // forces core_idle low
  logic        stub_hang;   // core never finishes once started

  always @(posedge clk) begin
    if (rst) begin
      stub_cnt <= '0;
      stub_vo0 <= '0;
      stub_vo1 <= '0;
    end else if (core_start) begin
      stub_cnt <= 4'd10;
      stub_vo0 <= core_vi0 ^ K;
      stub_vo1 <= core_vi1 ^ K;
    end else if (stub_cnt != 0 && !stub_hang) begin
      stub_cnt <= stub_cnt - 4'd1;
    end
  end

  assign core_idle = (stub_cnt == 4'd0) && !stub_hold;
  assign core_vo0  = stub_vo0;
  assign core_vo1  = stub_vo1;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] pack(input logic err, input logic [ID_W-1:0] id,
                                        input logic [31:0] v1, input logic [31:0] v0);
    return {err, id, v1, v0};
  endfunction

  // Scoreboard: every completed response handshake must match the head of
  // exp_q. An unexpected response is compared against all-ones, which no
  // legal response can equal.
  always @(negedge clk) begin : rsp_mon
    logic [W-1:0] exp_w;
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() != 0) exp_w = exp_q.pop_front();
      else exp_w = '1;
      check("rsp", {rsp_err, rsp_id, rsp_v1, rsp_v0}, exp_w);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic [31:0] v0, input logic [31:0] v1);
    req_v0[32*i +: 32] = v0;
    req_v1[32*i +: 32] = v1;
  endtask

  task automatic wait_ready(input string tag, input int lim);
    logic found;
    found = 1'b0;
    for (int n = 0; n < lim; n++) begin
      #1;
      if (req_ready != 0) begin
        found = 1'b1;
        break;
      end
      cyc();
    end
    check({tag, "_grant_seen"}, found, 1);
  endtask

  task automatic wait_rsp(input string tag, input int lim, output int n);
    n = 0;
    while (!rsp_valid && n < lim) begin
      cyc();
      n++;
    end
    check({tag, "_rsp_seen"}, rsp_valid, 1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((dbg_state != 2'd0 || exp_q.size() != 0) && n < 100) begin
      cyc();
      n++;
    end
    check({tag, "_idle"}, (dbg_state == 2'd0 && exp_q.size() == 0), 1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {req_ready, core_start, rsp_valid, rsp_id, rsp_err, dbg_state}, '0);
    check({tag, "_vi"},  {core_vi1, core_vi0}, '0);
    check({tag, "_rsp"}, {rsp_v1, rsp_v0}, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    cyc();
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] t2_v0[4], t2_v1[4], t2_e0[4], t2_e1[4];
  int          t2_ord[5];
  logic [W-1:0] snap;
  int          n, bad;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_v0    = '0;
    req_v1    = '0;
    rsp_ready = 1'b1;
    stub_hold = 1'b0;
    stub_hang = 1'b0;

    t2_v0 = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h00000003};
    t2_v1 = '{32'hF0000000, 32'hF0000001, 32'hF0000002, 32'hF0000003};
    t2_e0 = '{32'hA5A5A5A5, 32'hA5A5A5A4, 32'hA5A5A5A7, 32'hA5A5A5A6};
    t2_e1 = '{32'h55A5A5A5, 32'h55A5A5A4, 32'h55A5A5A7, 32'h55A5A5A6};
    t2_ord = '{0, 1, 2, 3, 0};

    // Reset state
    cyc();
    cyc();
    check_all_zero("rst");
    rst = 1'b0;
    cyc();

    // 1: single request from requester 0
    set_req(0, 32'h00000001, 32'h00000002);
    req_valid = 4'b0001;
    #1;
    check("t1_ready", req_ready, 4'b0001);
    exp_q.push_back(pack(1'b0, 2'd0, 32'hA5A5A5A7, 32'hA5A5A5A4));
    cyc();
    req_valid = '0;
    check("t1_start", core_start, 1);
    check("t1_vi", {core_vi1, core_vi0}, {32'h00000002, 32'h00000001});
    cyc();
    check("t1_start_low", core_start, 0);
    wait_rsp("t1", 40, n);
    check("t1_latency", n, 11);
    check("t1_rsp_fields", {rsp_err, rsp_id, rsp_v1, rsp_v0},
          pack(1'b0, 2'd0, 32'hA5A5A5A7, 32'hA5A5A5A4));
    cyc();
    check("t1_rsp_drop", rsp_valid, 0);
    wait_idle("t1");

    // 2: all requesters continuously valid, from a fresh reset
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, t2_v0[i], t2_v1[i]);
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ready($sformatf("t2_%0d", k), 40);
      check($sformatf("t2_grant%0d", k), req_ready, 4'b0001 << t2_ord[k]);
      exp_q.push_back(pack(1'b0, ID_W'(t2_ord[k]), t2_e1[t2_ord[k]], t2_e0[t2_ord[k]]));
      cyc();
    end
    req_valid = '0;
    wait_idle("t2");

    // 3: response back-pressure for 20 cycles
    rsp_ready = 1'b0;
    set_req(2, 32'hDEADBEEF, 32'h01234567);
    req_valid = 4'b0100;
    wait_ready("t3", 40);
    check("t3_grant", req_ready, 4'b0100);
    exp_q.push_back(pack(1'b0, 2'd2, 32'hA486E0C2, 32'h7B081B4A));
    cyc();
    set_req(3, 32'h00000000, 32'hFFFFFFFF);
    req_valid = 4'b1000;
    wait_rsp("t3", 40, n);
    snap = {rsp_err, rsp_id, rsp_v1, rsp_v0};
    check("t3_rsp_fields", snap, pack(1'b0, 2'd2, 32'hA486E0C2, 32'h7B081B4A));
    bad = 0;
    repeat (20) begin
      cyc();
      #1;
      if ({rsp_err, rsp_id, rsp_v1, rsp_v0} !== snap || req_ready != 0 || !rsp_valid) bad++;
    end
    check("t3_hold", bad, 0);
    rsp_ready = 1'b1;
    #1;
    check("t3_ready_in_resp", req_ready, 4'b0000);
    cyc();
    #1;
    check("t3_grant_after", req_ready, 4'b1000);
    exp_q.push_back(pack(1'b0, 2'd3, 32'h5A5A5A5A, 32'hA5A5A5A5));
    cyc();
    req_valid = '0;
    wait_idle("t3");

    // 4: core not idle at IDLE blocks the grant
    stub_hold = 1'b1;
    set_req(1, 32'h12345678, 32'h9ABCDEF0);
    req_valid = 4'b0010;
    bad = 0;
    repeat (6) begin
      #1;
      if (req_ready != 0) bad++;
      cyc();
    end
    check("t4_blocked", bad, 0);
    stub_hold = 1'b0;
    #1;
    check("t4_grant", req_ready, 4'b0010);
    exp_q.push_back(pack(1'b0, 2'd1, 32'h3F197B55, 32'hB791F3DD));
    cyc();
    req_valid = '0;
    wait_idle("t4");

    // 5: reset during BUSY drops the block; req0 wins the next grant
    set_req(2, 32'hCAFEF00D, 32'h0BADC0DE);
    req_valid = 4'b0100;
    wait_ready("t5", 40);
    check("t5_grant", req_ready, 4'b0100);
    cyc();
    req_valid = '0;
    repeat (3) cyc();
    check("t5_busy", dbg_state, 2'd2);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    check_all_zero("t5");
    set_req(0, 32'h00000000, 32'h00000000);
    req_valid = 4'b1111;
    #1;
    check("t5_first", req_ready, 4'b0001);
    exp_q.push_back(pack(1'b0, 2'd0, 32'hA5A5A5A5, 32'hA5A5A5A5));
    cyc();
    req_valid = '0;
    wait_idle("t5");

`ifdef TEA_SCHED_TIMEOUT_EN
    // 6: hung core produces an error response after TIMEOUT_CYC BUSY cycles
    stub_hang = 1'b1;
    set_req(3, 32'h11111111, 32'h22222222);
    req_valid = 4'b1000;
    wait_ready("t6", 40);
    check("t6_grant", req_ready, 4'b1000);
    exp_q.push_back(pack(1'b1, 2'd3, 32'h00000000, 32'h00000000));
    cyc();
    req_valid = '0;
    wait_rsp("t6", 60, n);
    check("t6_latency", n, 17);
    check("t6_err", rsp_err, 1);
    cyc();
    stub_hang = 1'b0;
    do_reset();
    wait_idle("t6");
`endif

    check("q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tea_rr_sched.md
# tea_rr_sched

- Round-robin scheduler that shares one `tea` encryption core between `N_REQ` requesters.
- Accepts one 64-bit plaintext block at a time, launches the core, waits for the core to finish, and returns the ciphertext tagged with the requester index.
- Sits between the requester-side valid/ready ports and the core's `start`/`idle` interface.
- An optional watchdog turns a hung core into an error response.

## Interface

Parameters:
- `N_REQ`, 4: number of requesters, 2..16.
- `ID_W`, 2: width of `rsp_id`; must satisfy N_REQ <= 2**ID_W.
- `TIMEOUT_CYC`, 512: watchdog limit in BUSY cycles. Nominal core run is 416 cycles. Used only with `TEA_SCHED_TIMEOUT_EN`.

Ports (clock and reset first):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high. Shared with the core.
- `req_valid` in N_REQ: per-requester block valid.
- `req_ready` out N_REQ: per-requester accept, one-hot or zero.
- `req_v0` in 32*N_REQ: word 0 of each requester; requester i occupies bits [32i+31:32i].
- `req_v1` in 32*N_REQ: word 1 of each requester, same packing.
- `core_start` out 1: to core `start`.
- `core_vi0`, `core_vi1` out 32 each: to core `vi0`/`vi1`.
- `core_idle` in 1: from core `idle`.
- `core_vo0`, `core_vo1` in 32 each: from core `vo0`/`vo1`.
- `rsp_valid` out 1: result available.
- `rsp_ready` in 1: downstream accepts the result.
- `rsp_v0`, `rsp_v1` out 32 each: ciphertext.
- `rsp_id` out ID_W: index of the requester that owns the result.
- `rsp_err` out 1: watchdog fired; data is invalid.

## Operation

FSM states: IDLE, LAUNCH, BUSY, RESP.

- **IDLE**
  - Grant condition: `core_idle`=1 and any `req_valid` set.
  - Winner g: first valid index searching upward from (last+1) mod N_REQ.
  - `req_ready[g]`=1 combinationally in the same cycle. This is the only path where ready depends on valid.
  - On that edge: latch `req_v0`/`req_v1` slice g into the launch registers, set id=g and last=g, go to LAUNCH.
  - With `core_idle`=0: `req_ready` stays all zero and the FSM stays in IDLE.
- **LAUNCH** (exactly 1 cycle)
  - `core_start`=1; `core_vi0`/`core_vi1` = latched words.
  - Next state BUSY; watchdog counter cleared.
- **BUSY**
  - `core_start`=0.
  - When `core_idle`=1 is sampled: capture `core_vo0`/`core_vo1` into the response registers, `rsp_err`=0, go to RESP.
  - A `core_idle` low in the first BUSY cycle is normal.
- **RESP**
  - `rsp_valid`=1; `rsp_v0`, `rsp_v1`, `rsp_id` and `rsp_err` are held stable.
  - On `rsp_valid`&`rsp_ready`: go to IDLE.
  - No new grant in RESP; the earliest next grant is the cycle after the handshake.

Rules:
- Requesters hold `req_valid` and data stable until they see `req_ready`. Dropping `req_valid` before grant is permitted.
- `core_vi0`/`core_vi1` hold the last latched words outside LAUNCH; the core ignores them there.
- Round robin: after requester g is served, g has the lowest priority in the next arbitration.
- Reset values:
  - FSM=IDLE, last=N_REQ-1 (requester 0 wins first).
  - All outputs 0; `req_ready`=0.
- Reset mid-operation: the FSM returns to IDLE and any in-flight block and response are dropped silently. The core is reset by the same `rst`.

## Timing

- Request handshake at cycle T, then:
  - `core_start`=1 in T+1;
  - the core reports busy from T+2;
  - `rsp_valid` rises the cycle after `core_idle` is first sampled high in BUSY.
- With the real core: handshake to `rsp_valid` is about 419 cycles.
- Minimum per-block overhead beyond core run time: 3 cycles (grant, LAUNCH, RESP with immediate `rsp_ready`).
- `rsp_*` outputs are registered. `req_ready` is combinational from `req_valid`, `core_idle` and FSM state.

## Configuration

Macro `TEA_SCHED_TIMEOUT_EN`.

Defined:
- A counter (clog2(TIMEOUT_CYC)+1 bits) increments each BUSY cycle.
- If it reaches TIMEOUT_CYC before `core_idle`=1: go to RESP with `rsp_err`=1, `rsp_v0`=`rsp_v1`=0, and `rsp_id` = the current id.
- IDLE still waits for `core_idle` before the next grant.

Undefined:
- No counter is built and `rsp_err` is tied to 0.
- BUSY waits for the core indefinitely.

## Test plan

Bench uses a stub core that goes busy for 10 cycles after `start` and returns vo = vi ^ 32'hA5A5A5A5.

1. Single request: req0 valid with v0=32'h00000001, v1=32'h00000002.
   - `req_ready[0]` high in the same cycle; `core_start` high 1 cycle later.
   - `rsp_valid` with v0=32'hA5A5A5A4, v1=32'hA5A5A5A7, id=0.
2. All four requesters held valid continuously → grants in order 0,1,2,3,0; each `rsp_id` matches its grant.
3. `rsp_ready` held low 20 cycles:
   - `rsp_*` stay stable;
   - no `req_ready` asserts until the cycle after the handshake.
4. Stub `core_idle`=0 at IDLE with req1 valid → `req_ready` stays 0 until `core_idle` returns to 1.
5. `rst` pulsed during BUSY → next cycle all outputs 0, FSM in IDLE; the next grant goes to req0.
6. With `TEA_SCHED_TIMEOUT_EN` and TIMEOUT_CYC=16, stub core never finishes → `rsp_valid` with `rsp_err`=1 and data 0, 16 cycles into BUSY.
